// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one iterative multiplier between NREQ requesters.
// Issues a one-cycle start, waits for done (or timeout) and routes the result back to the owner.
module mult_sched #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 20
) (
  input  logic               clk,
  input  logic               Nrst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [32*NREQ-1:0] req_acc,
  input  logic [32*NREQ-1:0] req_in0,
  input  logic [32*NREQ-1:0] req_in1,
  input  logic [NREQ-1:0]    abort,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [31:0]        rsp_data,
  output logic               err_timeout,
  output logic               mult_start,
  output logic [31:0]        mult_acc0,
  output logic [31:0]        mult_in0,
  output logic [31:0]        mult_in1,
  input  logic               mult_done,
  input  logic [31:0]        mult_result
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    r_state;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_owner;
  logic          r_killed;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_acc;
  logic [31:0]   r_in0;
  logic [31:0]   r_in1;
  logic [31:0]   r_rsp_data;
  logic          r_err;

  logic          w_grant_vld;
  logic [IW-1:0] w_grant_idx;
  logic [IW:0]   w_sum;
  logic [IW:0]   w_rr_next;
  logic [31:0]   w_sel_acc;
  logic [31:0]   w_sel_in0;
  logic [31:0]   w_sel_in1;
  logic          w_owner_abort;

  // Scan offsets from the highest down so the lowest offset from r_rr_ptr wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path that skips an assignment would infer a latch.
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (w_sum >= NREQ_W) w_sum = w_sum - NREQ_W;
      if (req_valid[w_sum[IW-1:0]] && !abort[w_sum[IW-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    w_sel_acc = '0;
    w_sel_in0 = '0;
    w_sel_in1 = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant_idx == IW'(k)) begin
        w_sel_acc = req_acc[32*k +: 32];
        w_sel_in0 = req_in0[32*k +: 32];
        w_sel_in1 = req_in1[32*k +: 32];
      end
    end
  end

  always_comb begin
    w_rr_next = {1'b0, w_grant_idx} + (IW+1)'(1);
    if (w_rr_next >= NREQ_W) w_rr_next = '0;
  end

  assign w_owner_abort = abort[r_owner];

  always_comb begin
    req_ready = '0;
    if (Nrst && r_state == S_IDLE && w_grant_vld) req_ready[w_grant_idx] = 1'b1;
  end

  // An abort arriving during RESP itself still suppresses the pulse.
  always_comb begin
    rsp_valid = '0;
    if (r_state == S_RESP && !r_killed && !w_owner_abort) rsp_valid[r_owner] = 1'b1;
  end

  assign rsp_data    = r_rsp_data;
  assign err_timeout = r_err;
  assign mult_start  = (r_state == S_START);
  assign mult_acc0   = r_acc;
  assign mult_in0    = r_in0;
  assign mult_in1    = r_in1;

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_killed   <= 1'b0;
      r_cnt      <= '0;
      // NOTE: the operand registers drive output ports directly, so they are reset like control state to keep those ports defined.
      r_acc      <= '0;
      r_in0      <= '0;
      r_in1      <= '0;
      r_rsp_data <= '0;
      r_err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge register values.
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_owner  <= w_grant_idx;
            r_acc    <= w_sel_acc;
            r_in0    <= w_sel_in0;
            r_in1    <= w_sel_in1;
            r_killed <= 1'b0;
            r_rr_ptr <= w_rr_next[IW-1:0];
            r_state  <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          if (w_owner_abort) r_killed <= 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_owner_abort) r_killed <= 1'b1;
          if (mult_done) begin
            r_rsp_data <= mult_result;
            // A killed op has nobody to answer, so skip RESP and free the multiplier at once.
            r_state    <= (r_killed || w_owner_abort) ? S_IDLE : S_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
